nt_homeostatic_level: RTL and testbench



---
 rtl/nt_homeostatic_level.sv | 109 ++++++++++
 tb/tb_nt_homeostatic_level.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/nt_homeostatic_level.sv
// Saturating neurotransmitter level with homeostatic decay toward DEFAULT_VAL,
// a post-setval hold window and a hysteretic quantised output level.
module nt_homeostatic_level #(
  parameter int unsigned N            = 7,
  parameter int unsigned DEFAULT_VAL  = 96,
  parameter int unsigned SET_VAL      = 64,
  parameter int unsigned FAST_STEP    = 3,
  parameter int unsigned DECAY_PERIOD = 16,
  parameter int unsigned HOLD_CYCLES  = 8,
  parameter int unsigned OUT_BITS     = 2,
  parameter int unsigned HYST         = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc,
  input  logic                dec,
  input  logic                fast,
  input  logic                setval,
  output logic [N-1:0]        value,
  output logic [OUT_BITS-1:0] level,
  output logic                at_max,
  output logic                at_min,
  output logic                holding
);

  localparam int unsigned SHIFT = N - OUT_BITS;
  localparam int unsigned PW    = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam int unsigned HW    = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int unsigned LAST  = (DECAY_PERIOD > 0) ? DECAY_PERIOD - 1 : 0;

  localparam logic [N:0]          MAX_W   = {1'b0, {N{1'b1}}};
  localparam logic [N-1:0]        DEF_V   = N'(DEFAULT_VAL);
  localparam logic [N-1:0]        SET_V   = N'(SET_VAL);
  localparam logic [N:0]          HYST_W  = (N+1)'(HYST);
  localparam logic [OUT_BITS-1:0] DEF_LVL = OUT_BITS'(DEFAULT_VAL >> SHIFT);

  if (OUT_BITS < 1 || OUT_BITS > N || FAST_STEP >= (2 ** N) ||
      DEFAULT_VAL >= (2 ** N) || SET_VAL >= (2 ** N) || HYST >= (2 ** SHIFT)) begin : g_bad_params
    $error("nt_homeostatic_level: illegal parameter combination");
  end

  logic [PW-1:0]       presc;
  logic [HW-1:0]       hold_cnt;
  logic                tick;
  logic [N:0]          value_w, step_w, sum_w, diff_w;
  logic [N-1:0]        value_nxt;
  logic [HW-1:0]       hold_nxt;
  logic [OUT_BITS-1:0] raw, level_nxt;
  logic [N:0]          raw_base, lvl_base;

  assign tick    = (DECAY_PERIOD != 0) && (presc == PW'(LAST));
  assign holding = (hold_cnt != '0);
  assign at_max  = (value == {N{1'b1}});
  assign at_min  = (value == '0);

  // Step arithmetic is one bit wider than the register so saturation never wraps.
  assign value_w = {1'b0, value};
  assign step_w  = fast ? (N+1)'(FAST_STEP) : (N+1)'(1);
  assign sum_w   = value_w + step_w;
  assign diff_w  = value_w - step_w;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    value_nxt = value;
    hold_nxt  = hold_cnt;
    if (setval) begin
      value_nxt = SET_V;
      hold_nxt  = HW'(HOLD_CYCLES);
    end else if (hold_cnt != '0) begin
      hold_nxt = hold_cnt - HW'(1);
    end else if (inc && !dec) begin
      value_nxt = (sum_w > MAX_W) ? MAX_W[N-1:0] : sum_w[N-1:0];
    end else if (dec && !inc) begin
      value_nxt = (value_w < step_w) ? '0 : diff_w[N-1:0];
    end else if (!inc && !dec && tick) begin
      if (value < DEF_V)      value_nxt = value + N'(1);
      else if (value > DEF_V) value_nxt = value - N'(1);
    end
  end

  // Level moves only once the value is HYST past the boundary of the new band.
  assign raw      = value[N-1:SHIFT];
  assign raw_base = (N+1)'(raw) << SHIFT;
  assign lvl_base = (N+1)'(level) << SHIFT;

  always_comb begin
    level_nxt = level;
    if (raw > level && value_w >= raw_base + HYST_W)
      level_nxt = raw;
    else if (raw < level && value_w + HYST_W < lvl_base)
      level_nxt = raw;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value    <= DEF_V;
      level    <= DEF_LVL;
      hold_cnt <= '0;
      presc    <= '0;
    end else begin
      value    <= value_nxt;
      level    <= level_nxt;
      hold_cnt <= hold_nxt;
      presc    <= (tick || DECAY_PERIOD == 0) ? '0 : presc + PW'(1);
    end
  end

endmodule

// File: tb/tb_nt_homeostatic_level.sv
// Scoreboard bench for nt_homeostatic_level: the driver queues hand-computed
// post-edge expectations, a negedge monitor pops and compares them.
module tb_nt_homeostatic_level;

  logic clk = 1'b0;
  logic rst_n, inc, dec, fast, setval;

  logic [6:0] value1;
  logic [1:0] level1;
  logic       holding1, at_max1, at_min1;
  logic [9:0] value2;
  logic [2:0] level2;
  logic       holding2, at_max2, at_min2;

  nt_homeostatic_level #(
    .N(7), .DEFAULT_VAL(96), .SET_VAL(64), .FAST_STEP(3), .DECAY_PERIOD(16),
    .HOLD_CYCLES(8), .OUT_BITS(2), .HYST(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .fast(fast), .setval(setval),
    .value(value1), .level(level1), .at_max(at_max1), .at_min(at_min1), .holding(holding1)
  );

  // Wide variant: no decay, no hold window.
  nt_homeostatic_level #(
    .N(10), .DEFAULT_VAL(96), .SET_VAL(64), .FAST_STEP(3), .DECAY_PERIOD(0),
    .HOLD_CYCLES(0), .OUT_BITS(3), .HYST(4)
  ) dut_wide (
    .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .fast(fast), .setval(setval),
    .value(value2), .level(level2), .at_max(at_max2), .at_min(at_min2), .holding(holding2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] name;
    logic         wide;
    int           value;   // -1 means don't care
    int           level;
    int           holding;
    int           at_max;
    int           at_min;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input logic [127:0] name, input logic [63:0] field,
                       input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %0s.%0s: got %0d, expected %0d (t=%0t)", name, field, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0) begin
      mon_e = sb.pop_front();
      if (!mon_e.wide) begin
        if (mon_e.value   >= 0) check(mon_e.name, "value",   int'(value1),   mon_e.value);
        if (mon_e.level   >= 0) check(mon_e.name, "level",   int'(level1),   mon_e.level);
        if (mon_e.holding >= 0) check(mon_e.name, "holding", int'(holding1), mon_e.holding);
        if (mon_e.at_max  >= 0) check(mon_e.name, "at_max",  int'(at_max1),  mon_e.at_max);
        if (mon_e.at_min  >= 0) check(mon_e.name, "at_min",  int'(at_min1),  mon_e.at_min);
      end else begin
        if (mon_e.value   >= 0) check(mon_e.name, "value",   int'(value2),   mon_e.value);
        if (mon_e.level   >= 0) check(mon_e.name, "level",   int'(level2),   mon_e.level);
        if (mon_e.holding >= 0) check(mon_e.name, "holding", int'(holding2), mon_e.holding);
        if (mon_e.at_max  >= 0) check(mon_e.name, "at_max",  int'(at_max2),  mon_e.at_max);
        if (mon_e.at_min  >= 0) check(mon_e.name, "at_min",  int'(at_min2),  mon_e.at_min);
      end
    end
  end

  task automatic exp1(input logic [127:0] nm, input int v, input int l, input int h);
    exp_t e;
    e.name = nm; e.wide = 1'b0; e.value = v; e.level = l; e.holding = h;
    e.at_max = (v < 0) ? -1 : int'(v == 127);
    e.at_min = (v < 0) ? -1 : int'(v == 0);
    sb.push_back(e);
  endtask

  task automatic exp2(input logic [127:0] nm, input int v, input int l, input int h);
    exp_t e;
    e.name = nm; e.wide = 1'b1; e.value = v; e.level = l; e.holding = h;
    e.at_max = (v < 0) ? -1 : int'(v == 1023);
    e.at_min = (v < 0) ? -1 : int'(v == 0);
    sb.push_back(e);
  endtask

  // Apply inputs, take one rising edge, then settle away from the edge.
  task automatic cyc(input logic i, input logic d, input logic f, input logic s, input logic r);
    rst_n = r; inc = i; dec = d; fast = f; setval = s;
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic i, input logic d, input logic f, input logic s,
                       input logic [127:0] nm, input int v, input int l, input int h);
    cyc(i, d, f, s, 1'b1);
    exp1(nm, v, l, h);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp1("reset", 96, 3, 0);
    exp2("reset_wide", 96, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; inc = 1'b0; dec = 1'b0; fast = 1'b0; setval = 1'b0;

    // Reset, then fast saturation up and down.
    do_reset();
    for (int k = 1; k <= 12; k++)
      step1(1, 0, 1, 0, "sat_inc", (96 + 3 * k > 127) ? 127 : 96 + 3 * k, 3, 0);
    for (int k = 1; k <= 42; k++)
      step1(0, 1, 1, 0, "dec_fast", 127 - 3 * k, -1, 0);
    step1(0, 1, 0, 0, "dec_slow", 0, -1, 0);
    step1(0, 1, 1, 0, "dec_floor", 0, 0, 0);

    // setval beats inc, hold window, restart of the window, reset mid-hold.
    do_reset();
    step1(1, 0, 0, 1, "set_inc", 64, 3, 1);
    for (int k = 2; k <= 9; k++)
      step1(1, 0, 0, 0, "hold_inc", 64, 2, (k <= 8) ? 1 : 0);
    step1(1, 0, 0, 0, "post_hold", 65, 2, 0);
    step1(0, 0, 0, 1, "set_again", 64, 2, 1);
    for (int k = 12; k <= 15; k++)
      step1(0, 0, 0, 0, "hold_idle", 64, 2, 1);
    step1(0, 0, 0, 1, "set_restart", 64, 2, 1);
    for (int k = 17; k <= 24; k++)
      step1(1, 0, 0, 0, "hold_restart", 64, 2, (k <= 23) ? 1 : 0);
    step1(1, 0, 0, 0, "restart_end", 65, 2, 0);
    step1(0, 0, 0, 1, "set_mid", 64, 2, 1);
    step1(1, 0, 0, 0, "hold_mid", 64, 2, 1);
    cyc(1, 0, 0, 0, 1'b0);
    exp1("rst_mid_hold", 96, 3, 0);

    // Decay upward from 64: one step per 16-cycle tick, stopping at 96.
    do_reset();
    step1(0, 0, 0, 1, "decay_set", 64, 3, 1);
    for (int k = 2; k <= 600; k++)
      step1(0, 0, 0, 0, "decay_up", 64 + ((k / 16 > 32) ? 32 : k / 16), 2, (k <= 8) ? 1 : 0);

    // Decay downward from 127.
    do_reset();
    for (int k = 1; k <= 11; k++)
      step1(1, 0, 1, 0, "decay_fill", (96 + 3 * k > 127) ? 127 : 96 + 3 * k, 3, 0);
    for (int k = 12; k <= 520; k++)
      step1(0, 0, 0, 0, "decay_down", (127 - k / 16 < 96) ? 96 : 127 - k / 16, 3, 0);

    // inc=dec=1 on the tick cycle swallows that tick.
    do_reset();
    step1(0, 0, 0, 1, "supp_set", 64, 3, 1);
    for (int k = 2; k <= 15; k++)
      step1(0, 0, 0, 0, "supp_idle", 64, 2, (k <= 8) ? 1 : 0);
    step1(1, 1, 0, 0, "tick_suppressed", 64, 2, 0);
    for (int k = 17; k <= 48; k++)
      step1(0, 0, 0, 0, "supp_after", 64 + int'(k >= 32) + int'(k >= 48), 2, 0);

    // Hysteresis around the 64 boundary.
    do_reset();
    step1(0, 0, 0, 1, "hy_set", 64, 3, 1);
    for (int k = 2; k <= 9; k++)
      step1(0, 0, 0, 0, "hy_hold", 64, 2, (k <= 8) ? 1 : 0);
    step1(0, 1, 1, 0, "hy_dn1", 61, 2, 0);
    step1(0, 1, 1, 0, "hy_dn2", 58, 2, 0);
    step1(1, 0, 1, 0, "hy_lvl1", 61, 1, 0);
    step1(1, 0, 0, 0, "hy_62", 62, 1, 0);
    step1(1, 0, 0, 0, "hy_63", 63, 1, 0);
    step1(1, 0, 0, 0, "hy_up64", 64, 1, 0);
    step1(1, 0, 0, 0, "hy_up65", 65, 1, 0);
    step1(1, 0, 0, 0, "hy_up66", 66, 1, 0);
    step1(1, 0, 0, 0, "hy_up67", 67, 1, 0);
    step1(1, 0, 0, 0, "hy_up68", 68, 1, 0);
    step1(0, 0, 0, 0, "hy_lvl_up", 68, 2, 0);
    step1(0, 0, 0, 0, "hy_lvl_up_hold", 68, 2, 0);
    for (int k = 1; k <= 5; k++)
      step1(0, 1, 0, 0, "hy_dn_slow", 68 - k, 2, 0);
    step1(0, 0, 0, 0, "hy_stay63", 63, 2, 0);
    step1(0, 1, 0, 0, "hy_dn62", 62, 2, 0);
    step1(0, 1, 0, 0, "hy_dn61", 61, 2, 0);
    step1(0, 1, 0, 0, "hy_stay60", 60, 2, 0);
    step1(0, 1, 0, 0, "hy_at59", 59, 2, 0);
    step1(1, 1, 0, 0, "hy_lvl_down", 59, 1, 0);
    step1(0, 0, 0, 0, "hy_down_hold", 59, 1, 0);

    // Wide variant: no hold, no decay, saturation at 1023.
    do_reset();
    cyc(1, 0, 0, 1, 1'b1);
    exp2("w_set", 64, 0, 0);
    cyc(1, 0, 0, 0, 1'b1);
    exp2("w_no_hold", 65, 0, 0);
    for (int k = 3; k <= 42; k++) begin
      cyc(0, 0, 0, 0, 1'b1);
      exp2("w_no_decay", 65, 0, 0);
    end
    for (int k = 1; k <= 320; k++) begin
      cyc(1, 0, 1, 0, 1'b1);
      exp2("w_sat", (65 + 3 * k > 1023) ? 1023 : 65 + 3 * k, -1, 0);
    end
    cyc(0, 0, 0, 0, 1'b1);
    exp2("w_max_idle", 1023, -1, 0);
    cyc(0, 0, 0, 0, 1'b1);
    exp2("w_max_level", 1023, 7, 0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
